// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time and
// reports the hex code of the first key found, holding that column until every
// row is released. Latency: press seen within 4*SCAN_DIV+2 cycles, release within
// SCAN_DIV+2 cycles. No backpressure: outputs are levels for a downstream debouncer.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   rows[3:0]           keypad rows, active-low, asynchronous to clk
//   cols[3:0]           column drive, active-low one-hot
//   key_code[3:0]       hex code of the held key (kept after release)
//   key_pressed         high while a key is held in the active column
//
// Build option: define KEYPAD_MULTI_REJECT_EN to treat two or more simultaneous
// low rows as "no key" while scanning, and to drop key_pressed while holding.

module keypad_scanner #(
    parameter int SCAN_DIV = 48000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_pressed
);

`ifdef KEYPAD_MULTI_REJECT_EN
    localparam bit MULTI_REJECT = 1'b1;
`else
    localparam bit MULTI_REJECT = 1'b0;
`endif

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {
        ST_SCAN = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    logic [3:0]    rows_s1_q, rows_s1_d;
    logic [3:0]    rs_q, rs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    col_q, col_d;
    state_t        state_q, state_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_pressed_q, key_pressed_d;

    logic          tick;
    logic [3:0]    row_low;
    logic          no_key;
    logic          multi_key;
    logic [1:0]    low_row;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;   // '*'
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;   // '#'
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer on the asynchronous row inputs.
    assign rows_s1_d = rows;
    assign rs_d      = rows_s1_q;

    // Dwell counter free-runs in both states; the column only moves on tick,
    // so the rows have SCAN_DIV-1 cycles to settle through the synchronizer.
    assign tick  = (cnt_q == CW'(SCAN_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    assign row_low   = ~rs_q;
    assign no_key    = (row_low == 4'h0);
    // Clearing the lowest set bit leaves something only if two or more rows are low.
    assign multi_key = ((row_low & (row_low - 4'd1)) != 4'h0);

    always_comb begin
        low_row = 2'd3;
        if (row_low[2]) low_row = 2'd2;
        if (row_low[1]) low_row = 2'd1;
        if (row_low[0]) low_row = 2'd0;
    end

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        key_code_d    = key_code_q;
        key_pressed_d = key_pressed_q;
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (no_key || (MULTI_REJECT && multi_key)) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        state_d       = ST_HOLD;
                        key_code_d    = key_map(low_row, col_q);
                        key_pressed_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (no_key) begin
                        state_d       = ST_SCAN;
                        key_pressed_d = 1'b0;
                        col_d         = col_q + 2'd1;
                    end else if (MULTI_REJECT && multi_key) begin
                        // Stay parked on this column until all rows release.
                        key_pressed_d = 1'b0;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_s1_q     <= 4'hF;
            rs_q          <= 4'hF;
            cnt_q         <= '0;
            col_q         <= 2'd0;
            state_q       <= ST_SCAN;
            key_code_q    <= 4'h0;
            key_pressed_q <= 1'b0;
        end else begin
            rows_s1_q     <= rows_s1_d;
            rs_q          <= rs_d;
            cnt_q         <= cnt_d;
            col_q         <= col_d;
            state_q       <= state_d;
            key_code_q    <= key_code_d;
            key_pressed_q <= key_pressed_d;
        end
    end

    assign cols        = ~(4'b0001 << col_q);
    assign key_code    = key_code_q;
    assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives keypad_scanner through a model of a physical 4x4
// keypad and compares every cycle against a behavioural reference model.
// Latency: n/a. Backpressure: n/a.

module tb_keypad_scanner;

    localparam int DIV = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_pressed;

    logic [15:0] keys   = 16'h0;   // bit r*4+c set = key at row r, column c held
    logic        ovr_en = 1'b0;
    logic [3:0]  ovr_val = 4'hF;

    int total = 0;
    int bad   = 0;

    keypad_scanner #(.SCAN_DIV(DIV)) dut (
        .clk         (clk),
        .reset       (rst),
        .rows        (rows),
        .cols        (cols),
        .key_code    (key_code),
        .key_pressed (key_pressed)
    );

    always #5 clk = ~clk;

    // Physical keypad: a held key pulls its row low while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && (cols[c] == 1'b0)) rows[r] = 1'b0;
        if (ovr_en) rows = ovr_val;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] kb(input int r, input int c);
        logic [15:0] v;
        v = 16'h0;
        v[r*4+c] = 1'b1;
        return v;
    endfunction

    // ---------------- reference model ----------------
    int         kmap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
    bit         reject;
    int         m_n;        // index of the next clock edge since reset release
    int         m_col;
    bit         m_held;
    bit         m_pressed;
    logic [3:0] m_code;
    logic [3:0] m_pipe [$]; // rows seen at the last two edges
    logic [3:0] m_rs, m_low;
    int         m_nlow, m_row;

    initial begin
`ifdef KEYPAD_MULTI_REJECT_EN
        reject = 1'b1;
`else
        reject = 1'b0;
`endif
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = 0; m_col = 0; m_held = 0; m_pressed = 0; m_code = 4'h0;
            m_pipe = '{4'hF, 4'hF};
        end else begin
            // Decisions use the rows as they were two edges ago.
            m_rs = m_pipe.pop_front();
            m_pipe.push_back(rows);
            if (m_n % DIV == DIV - 1) begin
                m_low  = ~m_rs;
                m_nlow = $countones(m_low);
                m_row  = 0;
                for (int i = 3; i >= 0; i--) if (m_low[i]) m_row = i;
                if (!m_held) begin
                    if (m_nlow == 0 || (reject && m_nlow >= 2)) begin
                        m_col = (m_col + 1) % 4;
                    end else begin
                        m_held = 1; m_pressed = 1;
                        m_code = 4'(kmap[m_row][m_col]);
                    end
                end else begin
                    if (m_nlow == 0) begin
                        m_held = 0; m_pressed = 0;
                        m_col = (m_col + 1) % 4;
                    end else if (reject && m_nlow >= 2) begin
                        m_pressed = 0;
                    end
                end
            end
            m_n++;
        end
    end

    logic [3:0] exp_cols;
    always @(negedge clk) begin
        if (!rst) begin
            exp_cols = 4'hF;
            exp_cols[m_col] = 1'b0;
            check("model_cols", cols, exp_cols);
            check("model_code", key_code, m_code);
            check("model_pressed", key_pressed, m_pressed);
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic wait_level(input string tag, input logic lvl, input int budget);
        int k;
        k = 0;
        while (key_pressed !== lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, key_pressed, lvl);
    endtask

    logic [3:0] step_seq [5];
    bit         saw;
    int         changes;
    logic [3:0] prev_cols;

    initial begin
        step_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Async reset arriving mid-HOLD.
        keys = kb(0, 0);
        wait_level("press_1", 1'b1, 4*DIV + 2);
        check("code_1", key_code, 4'h1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_cols", cols, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_pressed", key_pressed, 1'b0);
        keys = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("step_cols", cols, step_seq[i]);
            repeat (DIV) @(posedge clk);
        end

        // Key "5": press, hold, release.
        @(negedge clk);
        keys = kb(1, 1);
        wait_level("press_5", 1'b1, 4*DIV + 2);
        check("code_5", key_code, 4'h5);
        repeat (3*DIV) @(negedge clk);
        check("hold_cols_5", cols, 4'b1101);
        keys = 16'h0;
        wait_level("release_5", 1'b0, DIV + 2);
        check("code_5_kept", key_code, 4'h5);
        check("cols_after_5", cols, 4'b1011);

        // "*" held, then "0" added in another column.
        keys = kb(3, 0);
        wait_level("press_star", 1'b1, 4*DIV + 2);
        check("code_star", key_code, 4'hE);
        keys = keys | kb(3, 1);
        repeat (3*DIV) @(negedge clk);
        check("code_star_kept", key_code, 4'hE);
        check("pressed_star_kept", key_pressed, 1'b1);
        keys = 16'h0;
        wait_level("release_star", 1'b0, DIV + 2);

        // "1" and "4" together in column 0.
        keys = kb(0, 0) | kb(1, 0);
`ifdef KEYPAD_MULTI_REJECT_EN
        saw = 1'b0; changes = 0; prev_cols = cols;
        repeat (5*DIV) begin
            @(negedge clk);
            saw = saw | key_pressed;
            if (cols != prev_cols) changes++;
            prev_cols = cols;
        end
        check("multi_reject_pressed", saw, 1'b0);
        check("multi_reject_stepping", (changes >= 4), 1'b1);
`else
        wait_level("press_1_4", 1'b1, 4*DIV + 2);
        check("code_1_4", key_code, 4'h1);
`endif
        keys = 16'h0;
        wait_level("release_1_4", 1'b0, DIV + 2);

        // 3-cycle row glitch placed entirely between ticks.
        begin
            int k;
            k = 0;
            while ((m_n % DIV) != 0 && k < 2*DIV) begin
                @(negedge clk);
                k++;
            end
        end
        ovr_val = 4'b1101;
        ovr_en  = 1'b1;
        saw     = 1'b0;
        repeat (3) @(negedge clk);
        ovr_en  = 1'b0;
        repeat (3*DIV) begin
            @(negedge clk);
            saw = saw | key_pressed;
        end
        check("glitch_ignored", saw, 1'b0);

        // Random key combinations checked by the reference model every cycle.
        for (int it = 0; it < 40; it++) begin
            int nk;
            keys = 16'h0;
            nk = $urandom_range(0, 2);
            for (int j = 0; j < nk; j++)
                keys = keys | kb($urandom_range(0, 3), $urandom_range(0, 3));
            repeat ($urandom_range(5, 60)) @(negedge clk);
        end
        keys = 16'h0;
        repeat (2*DIV + 4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Drives the columns of a 4x4 matrix keypad, samples the rows, and reports the hex code of a pressed key. It sits directly upstream of the keypad debouncer, feeding it a 4-bit `key_code` and a raw `key_pressed` level. The scanner does no debouncing of its own. It stops on the first key it finds and holds that column until every row is released.

## Interface
- `SCAN_DIV`, default 48000: column dwell in `clk` cycles (1 ms at 48 MHz); legal minimum 4.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rows`  in  4  keypad rows; active-low, externally pulled up, asynchronous to `clk`.
- `cols`  out  4  keypad column drive; active-low one-hot.
- `key_code`  out  4  hex value of the held key.
- `key_pressed`  out  1  high while a key is held in the active column.

## Operation
- `rows` passes through a 2-flop synchronizer; all logic uses the synchronized value `rs`.
- Dwell counter:
  - Width `$clog2(SCAN_DIV)`; counts 0..SCAN_DIV-1, then wraps.
  - `tick` is asserted when the count equals SCAN_DIV-1.
  - The counter runs in both states.
- Column index `c` (0..3) gives `cols = ~(4'b0001 << c)`.
- State SCAN:
  - On `tick` with `rs == 4'hF`: `c` advances to `c+1 mod 4`.
  - On `tick` with any row low: go to HOLD and keep `c`.
  - Row `r` is the lowest-index low row.
  - `key_code` loads `map(r,c)` and `key_pressed` goes to 1.
- State HOLD:
  - `c` is frozen and `key_code` is stable.
  - On `tick` with `rs == 4'hF`: go to SCAN, `key_pressed` goes to 0, and `c` advances to `c+1`.
  - Otherwise stay in HOLD.
  - A change of which row is low while in HOLD does not alter `key_code`.
- Key map, rows r0..r3 by columns c0..c3:
  - r0 = 1,2,3,A
  - r1 = 4,5,6,B
  - r2 = 7,8,9,C
  - r3 = E,0,F,D (E is `*`, F is `#`)
- `key_code` keeps its last value after release; it changes only on a SCAN-to-HOLD transition.

## Timing
- Reset values: SCAN, counter 0, `c` = 0, `cols` = 4'b1110, `key_code` = 4'h0, `key_pressed` = 0.
- Reset is asynchronous and may arrive mid-HOLD. The outputs return to their reset values immediately, with no glitch beyond the reset assertion.
- `cols` changes only on the clock edge after a `tick`. This gives SCAN_DIV-1 cycles of settle, which covers the 2-cycle synchronizer latency.
- Press latency, from a row going low at the pins to `key_pressed` high: at most 4*SCAN_DIV + 2 cycles.
- `key_code` and `key_pressed` update on the same edge.
- Release latency: at most SCAN_DIV + 2 cycles.
- If press and release both fall within one dwell window, only the value sampled at `tick` counts; transients between ticks are invisible.
- Multiple keys in different columns: the first column scanned wins.
- Multiple keys in the same column: the lowest row index wins, unless the multi-key reject option below is compiled in.

## Configuration
- `KEYPAD_MULTI_REJECT_EN`, when defined:
  - In SCAN, a `tick` with two or more rows low is treated as no key, and scanning continues.
  - In HOLD, if a `tick` sees a second row low, `key_pressed` drops to 0 and the FSM stays in HOLD until `rs == 4'hF`, then returns to SCAN as normal. `key_code` is unchanged.
- When `KEYPAD_MULTI_REJECT_EN` is undefined: the lowest row wins and extra keys are ignored, as described in Operation.

## Test plan
All scenarios use `SCAN_DIV` = 8.
- Reset asserted asynchronously mid-cycle -> `cols` = 1110, `key_code` = 0 and `key_pressed` = 0 before the next edge. After release, `cols` steps 1110, 1101, 1011, 0111, 1110 every 8 cycles.
- Model key "5" (row 1 low only while `cols` = 1101) -> `key_pressed` = 1 and `key_code` = 4'h5 within 34 cycles. `cols` then stays at 1101 while the key is held.
- Release "5" -> `key_pressed` = 0 within 10 cycles, `key_code` stays 5, and `cols` advances to 1011.
- Press "*" (row 3, column 0), then "0" (row 3, column 1) while holding "*" -> `key_code` = E and stays E.
- Press "1" and "4" together (column 0, rows 0 and 1):
  - Without the macro: `key_code` = 1 and `key_pressed` = 1.
  - With `KEYPAD_MULTI_REJECT_EN`: `key_pressed` stays 0 and `cols` keeps stepping.
- A row pulse low for 3 cycles falling between ticks -> no `key_pressed` assertion.
